// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I opcodes, ALU-type encoding and datapath defaults
package rv32i_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int RA_W_DEFAULT = 5;
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] L_TYPE = 7'b0000011;
  localparam logic [6:0] S_TYPE = 7'b0100011;
  localparam logic [6:0] B_TYPE = 7'b1100011;
  localparam logic [6:0] J_TYPE = 7'b1101111;
  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_FUNCT  = 2'b01,
    ALU_BRANCH = 2'b10
  } alu_type_e;
endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// hazard_unit: combinational load-use detection and stall/flush/bubble control
module hazard_unit import rv32i_pkg::*; #(
  parameter int RA_W = RA_W_DEFAULT
) (
  input  logic            wb_sel_e,
  input  logic            valid_e,
  input  logic [RA_W-1:0] rd_addr_e,
  input  logic [RA_W-1:0] rs1_addr_d,
  input  logic [RA_W-1:0] rs2_addr_d,
  input  logic            pc_src_e,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d,
  output logic            bubble_e
);
  logic lw_hazard;
  // rs1/rs2 compared regardless of opcode: spurious stalls are harmless
  assign lw_hazard = wb_sel_e & valid_e & (rd_addr_e != '0) &
                     ((rd_addr_e == rs1_addr_d) | (rd_addr_e == rs2_addr_d));
  // a redirect discards the decode instruction, so it overrides the stall
  assign stall_f  = lw_hazard & ~pc_src_e;
  assign stall_d  = stall_f;
  assign flush_d  = pc_src_e;
  assign bubble_e = lw_hazard | pc_src_e;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall and branch flush bubbles
module id_ex_stage import rv32i_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int RA_W = RA_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      alu_type_sel_d,
  input  logic            b_imm_sel_d,
  input  logic            branch_d,
  input  logic            jump_d,
  input  logic            memwrite_en_d,
  input  logic            regwrite_en_d,
  input  logic            wb_sel_d,
  input  logic [2:0]      funct3_d,
  input  logic            funct7b5_d,
  input  logic [RA_W-1:0] rs1_addr_d,
  input  logic [RA_W-1:0] rs2_addr_d,
  input  logic [RA_W-1:0] rd_addr_d,
  input  logic [XLEN-1:0] rs1_data_d,
  input  logic [XLEN-1:0] rs2_data_d,
  input  logic [XLEN-1:0] imm_ext_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc_plus4_d,
  input  logic            pc_src_e,
  output logic [1:0]      alu_type_sel_e,
  output logic            b_imm_sel_e,
  output logic            branch_e,
  output logic            jump_e,
  output logic            memwrite_en_e,
  output logic            regwrite_en_e,
  output logic            wb_sel_e,
  output logic [2:0]      funct3_e,
  output logic            funct7b5_e,
  output logic [RA_W-1:0] rs1_addr_e,
  output logic [RA_W-1:0] rs2_addr_e,
  output logic [RA_W-1:0] rd_addr_e,
  output logic [XLEN-1:0] rs1_data_e,
  output logic [XLEN-1:0] rs2_data_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pc_plus4_e,
  output logic            valid_e,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d
);
  localparam int W = 13 + 3 * RA_W + 5 * XLEN;
  logic [W-1:0] ex_q;
  logic         bubble_e;
  hazard_unit #(.RA_W(RA_W)) u_hazard (
    .wb_sel_e   (wb_sel_e),
    .valid_e    (valid_e),
    .rd_addr_e  (rd_addr_e),
    .rs1_addr_d (rs1_addr_d),
    .rs2_addr_d (rs2_addr_d),
    .pc_src_e   (pc_src_e),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .bubble_e   (bubble_e)
  );
  // a bubble zeroes every field, so it can never write or redirect
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ex_q <= '0;
    else ex_q <= bubble_e ? '0 : {1'b1, alu_type_sel_d, b_imm_sel_d, branch_d, jump_d,
                                  memwrite_en_d, regwrite_en_d, wb_sel_d, funct3_d, funct7b5_d,
                                  rs1_addr_d, rs2_addr_d, rd_addr_d, rs1_data_d, rs2_data_d,
                                  imm_ext_d, pc_d, pc_plus4_d};
  assign {valid_e, alu_type_sel_e, b_imm_sel_e, branch_e, jump_e, memwrite_en_e,
          regwrite_en_e, wb_sel_e, funct3_e, funct7b5_e, rs1_addr_e, rs2_addr_e,
          rd_addr_e, rs1_data_e, rs2_data_e, imm_ext_e, pc_e, pc_plus4_e} = ex_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random scoreboard checks of the ID/EX register and hazard control
module tb_id_ex_stage;
  typedef struct packed {
    logic [1:0]  alu;
    logic        bimm, br, jmp, mw, rw, wb;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc, pc4;
  } dec_t;
  typedef struct packed {
    logic valid;
    dec_t d;
  } ex_t;
  logic clk = 0, rst_n = 0, psrc = 0;
  dec_t d = '0;
  ex_t  obs, model, exp_q[$];
  logic stall_f, stall_d, flush_d;
  int   n_assert = 0, n_fail = 0;
  always #5 clk = ~clk;
  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .alu_type_sel_d(d.alu), .b_imm_sel_d(d.bimm), .branch_d(d.br), .jump_d(d.jmp),
    .memwrite_en_d(d.mw), .regwrite_en_d(d.rw), .wb_sel_d(d.wb), .funct3_d(d.f3),
    .funct7b5_d(d.f7), .rs1_addr_d(d.rs1), .rs2_addr_d(d.rs2), .rd_addr_d(d.rd),
    .rs1_data_d(d.d1), .rs2_data_d(d.d2), .imm_ext_d(d.imm), .pc_d(d.pc), .pc_plus4_d(d.pc4),
    .pc_src_e(psrc),
    .alu_type_sel_e(obs.d.alu), .b_imm_sel_e(obs.d.bimm), .branch_e(obs.d.br),
    .jump_e(obs.d.jmp), .memwrite_en_e(obs.d.mw), .regwrite_en_e(obs.d.rw),
    .wb_sel_e(obs.d.wb), .funct3_e(obs.d.f3), .funct7b5_e(obs.d.f7),
    .rs1_addr_e(obs.d.rs1), .rs2_addr_e(obs.d.rs2), .rd_addr_e(obs.d.rd),
    .rs1_data_e(obs.d.d1), .rs2_data_e(obs.d.d2), .imm_ext_e(obs.d.imm), .pc_e(obs.d.pc),
    .pc_plus4_e(obs.d.pc4), .valid_e(obs.valid),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d)
  );
  task automatic chk(input string tag, input logic [191:0] o, input logic [191:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  function automatic logic hz(input ex_t m, input dec_t x);
    return m.d.wb & m.valid & (m.d.rd != 0) & ((m.d.rd == x.rs1) | (m.d.rd == x.rs2));
  endfunction
  // drive one decode slot, check the combinational controls, then the captured EX state
  task automatic cyc(input string tag, input dec_t x, input logic ps);
    logic h;
    ex_t  e;
    d = x;
    psrc = ps;
    #1;
    h = hz(model, x);
    chk({tag, ".stall_f"}, 192'(stall_f), 192'(h & ~ps));
    chk({tag, ".stall_d"}, 192'(stall_d), 192'(h & ~ps));
    chk({tag, ".flush_d"}, 192'(flush_d), 192'(ps));
    exp_q.push_back((h | ps) ? ex_t'('0) : ex_t'({1'b1, x}));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".ex"}, 192'(obs), 192'(e));
    model = e;
  endtask
  function automatic dec_t mk(input logic [1:0] alu, input logic rw, input logic wb,
                              input logic mw, input logic jmp, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] d1, input logic [31:0] d2);
    dec_t x = '0;
    x.alu = alu; x.rw = rw; x.wb = wb; x.mw = mw; x.jmp = jmp;
    x.rs1 = rs1; x.rs2 = rs2; x.rd = rd; x.d1 = d1; x.d2 = d2;
    x.imm = 32'h4; x.pc = {22'h0, rs1, rs2}; x.pc4 = x.pc + 4;
    return x;
  endfunction
  initial begin
    dec_t add_i, lw_i, use_i;
    model = '0;
    #3;
    chk("reset.ex", 192'(obs), 192'(0));
    chk("reset.ctl", 192'({stall_f, stall_d, flush_d}), 192'(0));
    #4 rst_n = 1;
    @(negedge clk);
    add_i = mk(2'b01, 1, 0, 0, 0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    cyc("plain", add_i, 0);
    chk("plain.rs1_data", 192'(obs.d.d1), 192'(5));
    chk("plain.rs2_data", 192'(obs.d.d2), 192'(7));
    chk("plain.alu", 192'({obs.d.alu, obs.d.rw, obs.valid}), 192'({2'b01, 1'b1, 1'b1}));
    lw_i  = mk(2'b00, 1, 1, 0, 0, 5'd2, 5'd0, 5'd5, 32'h100, 32'h0);
    use_i = mk(2'b01, 1, 0, 0, 0, 5'd5, 5'd1, 5'd6, 32'h11, 32'h22);
    cyc("lu.load", lw_i, 0);
    cyc("lu.stall", use_i, 0);
    chk("lu.bubble", 192'({obs.valid, obs.d.rw}), 192'(0));
    cyc("lu.resume", use_i, 0);
    cyc("x0.load", mk(2'b00, 1, 1, 0, 0, 5'd4, 5'd0, 5'd0, 32'h8, 32'h0), 0);
    cyc("x0.use", mk(2'b01, 1, 0, 0, 0, 5'd0, 5'd0, 5'd9, 32'h1, 32'h2), 0);
    cyc("fl.jump", mk(2'b00, 1, 0, 0, 1, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0), 0);
    cyc("fl.flush", mk(2'b00, 0, 0, 1, 1, 5'd3, 5'd4, 5'd0, 32'h33, 32'h44), 1);
    chk("fl.bubble", 192'({obs.valid, obs.d.mw, obs.d.jmp}), 192'(0));
    cyc("flh.load", mk(2'b00, 1, 1, 0, 0, 5'd1, 5'd0, 5'd7, 32'h20, 32'h0), 0);
    cyc("flh.both", mk(2'b01, 1, 0, 0, 0, 5'd3, 5'd7, 5'd8, 32'h1, 32'h2), 1);
    cyc("rst.load", mk(2'b00, 1, 1, 0, 0, 5'd1, 5'd0, 5'd9, 32'h30, 32'h0), 0);
    d = mk(2'b01, 1, 0, 0, 0, 5'd9, 5'd2, 5'd10, 32'hAA, 32'hBB);
    #1;
    chk("rst.stall_pre", 192'({stall_f, stall_d}), 192'(2'b11));
    rst_n = 0;
    #1;
    chk("rst.ex_async", 192'(obs), 192'(0));
    chk("rst.ctl_async", 192'({stall_f, stall_d, flush_d}), 192'(0));
    @(negedge clk);
    rst_n = 1;
    model = '0;
    cyc("rst.after", d, 0);
    chk("rst.valid", 192'(obs.valid), 192'(1));
    for (int i = 0; i < 40; i++) begin
      dec_t r;
      r = dec_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      r.rs1 = 5'($urandom_range(0, 3));
      r.rs2 = 5'($urandom_range(0, 3));
      r.rd  = 5'($urandom_range(0, 3));
      cyc("rand", r, ($urandom_range(0, 5) == 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
